// File: rtl/line_position_estimator.sv
// Line position estimator: synchronises and debounces N reflectance sensors, then scans
// the debounced vector once per sample tick to produce position, line-lost, junction and side flags.
module line_position_estimator #(
  parameter int N_SENSORS         = 8,
  parameter int POS_W             = 11,
  parameter int HALF_STEP         = 64,
  parameter int SENSOR_ACTIVE_LOW = 1,
  parameter int FILT_LEN          = 4,
  parameter int SAMPLE_DIV        = 1000,
  parameter int LOST_TIMEOUT      = 8,
  parameter int LOST_CODE         = 2047
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SENSORS-1:0] sensors,
  output logic [POS_W-1:0]     position,
  output logic                 pos_valid,
  output logic                 line_lost,
  output logic                 junction,
  output logic                 lost_side
);

  localparam int IDX_W  = $clog2(N_SENSORS);
  localparam int SUM_W  = IDX_W + 1;
  localparam int CNT_W  = $clog2(N_SENSORS + 1);
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int FLT_W  = 4;
  localparam int LOST_W = 8;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_SENSORS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [SUM_W-1:0]  MID_SUM   = SUM_W'(N_SENSORS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ALL   = CNT_W'(N_SENSORS);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [FLT_W-1:0]  FLT_ONE   = FLT_W'(1);
  localparam logic [FLT_W-1:0]  FLT_FULL  = FLT_W'(FILT_LEN);
  localparam logic [LOST_W-1:0] LOST_ONE  = LOST_W'(1);
  localparam logic [LOST_W-1:0] LOST_MAX  = LOST_W'(LOST_TIMEOUT);
  localparam logic [POS_W-1:0]  STEP_C    = POS_W'(HALF_STEP);
  localparam logic [POS_W-1:0]  LOST_C    = POS_W'(LOST_CODE);

  typedef enum logic [1:0] {IDLE, SCAN, CALC} state_t;

  logic [N_SENSORS-1:0] sync_q1, sync_q2, act;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [N_SENSORS-1:0] deb, deb_next;
  logic [FLT_W-1:0]     flt_cnt  [N_SENSORS];
  logic [FLT_W-1:0]     flt_next [N_SENSORS];

  state_t               state, state_next;
  logic                 start, scan_en, calc_en;
  logic [N_SENSORS-1:0] snap;
  logic [IDX_W-1:0]     idx, min_idx, max_idx;
  logic [CNT_W-1:0]     hit_cnt;
  logic [LOST_W-1:0]    lost_cnt, lost_next;
  logic [SUM_W-1:0]     sum;

  // Two-flop synchroniser; act[i] is 1 when sensor i sees the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sensors;
      sync_q2 <= sync_q1;
    end
  end

  assign act  = (SENSOR_ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_ONE;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    deb_next = deb;
    flt_next = flt_cnt;
    if (tick) begin
      for (int i = 0; i < N_SENSORS; i++) begin
        if (act[i] == deb[i]) begin
          flt_next[i] = '0;
        end else if (flt_cnt[i] + FLT_ONE == FLT_FULL) begin
          deb_next[i] = act[i];
          flt_next[i] = '0;
        end else begin
          flt_next[i] = flt_cnt[i] + FLT_ONE;
        end
      end
    end
  end

  // NOTE: the per-bit filter counters are a handful of flops, not a RAM, so they take the reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < N_SENSORS; i++) flt_cnt[i] <= '0;
    end else begin
      deb     <= deb_next;
      flt_cnt <= flt_next;
    end
  end

  // NOTE: state and datapath registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = SCAN;
      SCAN:    if (idx == LAST_IDX) state_next = CALC;
      CALC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start   = (state == IDLE) && tick;
    scan_en = (state == SCAN);
    calc_en = (state == CALC);
  end

  assign sum       = {1'b0, min_idx} + {1'b0, max_idx};
  assign lost_next = (lost_cnt == LOST_MAX) ? lost_cnt : lost_cnt + LOST_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap      <= '0;
      idx       <= '0;
      min_idx   <= '0;
      max_idx   <= '0;
      hit_cnt   <= '0;
      lost_cnt  <= '0;
      position  <= '0;
      pos_valid <= 1'b0;
      line_lost <= 1'b0;
      junction  <= 1'b0;
      lost_side <= 1'b0;
    end else begin
      pos_valid <= calc_en;
      if (start) begin
        snap    <= deb_next;
        idx     <= '0;
        min_idx <= LAST_IDX;
        max_idx <= '0;
        hit_cnt <= '0;
      end
      if (scan_en) begin
        if (snap[idx]) begin
          if (idx < min_idx) min_idx <= idx;
          if (idx > max_idx) max_idx <= idx;
          hit_cnt <= hit_cnt + CNT_ONE;
        end
        idx <= idx + IDX_ONE;
      end
      if (calc_en) begin
        if (hit_cnt != '0) begin
          position  <= POS_W'(sum) * STEP_C;
          lost_cnt  <= '0;
          line_lost <= 1'b0;
          junction  <= (hit_cnt == CNT_ALL);
          // A line centred exactly on the array keeps the previous side.
          if (sum > MID_SUM)      lost_side <= 1'b1;
          else if (sum < MID_SUM) lost_side <= 1'b0;
        end else begin
          lost_cnt <= lost_next;
          junction <= 1'b0;
          if (lost_next == LOST_MAX) begin
            position  <= LOST_C;
            line_lost <= 1'b1;
          end else begin
            line_lost <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_line_position_estimator.sv
// Directed bench for line_position_estimator with N=8, SAMPLE_DIV=16, FILT_LEN=3;
// each step waits for the next pos_valid strobe and checks hand-computed outputs.
module tb_line_position_estimator;

  localparam int N   = 8;
  localparam int DIV = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] sensors;
  logic [10:0]  position;
  logic         pos_valid, line_lost, junction, lost_side;

  int vectors   = 0;
  int errors    = 0;
  int cyc;
  int valid_cyc = 0;

  line_position_estimator #(
    .N_SENSORS(N), .POS_W(11), .HALF_STEP(64), .SENSOR_ACTIVE_LOW(1),
    .FILT_LEN(3), .SAMPLE_DIV(DIV), .LOST_TIMEOUT(8), .LOST_CODE(2047)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sensors(sensors), .position(position),
    .pos_valid(pos_valid), .line_lost(line_lost), .junction(junction),
    .lost_side(lost_side)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; a tick edge falls on every multiple of DIV.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next strobe, check its timing and width.
  task automatic next_scan(input string tag);
    int waited = 0;
    while (pos_valid !== 1'b1 && waited < 3 * DIV) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " strobe seen"}, 32'(pos_valid), 32'd1);
    valid_cyc = cyc;
    check({tag, " latency"}, 32'(cyc % DIV), 32'd9);
    @(negedge clk);
    check({tag, " strobe width"}, 32'(pos_valid), 32'd0);
  endtask

  task automatic scan_check(input string tag, input int pos, input bit lost,
                            input bit junc, input bit side);
    next_scan(tag);
    check({tag, " position"},  32'(position),  32'(pos));
    check({tag, " line_lost"}, 32'(line_lost), 32'(lost));
    check({tag, " junction"},  32'(junction),  32'(junc));
    check({tag, " lost_side"}, 32'(lost_side), 32'(side));
  endtask

  initial begin
    rst_n   = 1'b0;
    sensors = 8'b1110_0111;
    repeat (3) @(negedge clk);
    check("reset position",  32'(position),  32'd0);
    check("reset pos_valid", 32'(pos_valid), 32'd0);
    check("reset line_lost", 32'(line_lost), 32'd0);
    check("reset junction",  32'(junction),  32'd0);
    check("reset lost_side", 32'(lost_side), 32'd0);
    rst_n = 1'b1;

    // Centre line: two empty scans while the debounce fills, then 448.
    scan_check("centre s1", 0, 0, 0, 0);
    check("first strobe cycle", 32'(valid_cyc), 32'd25);
    scan_check("centre s2", 0, 0, 0, 0);
    scan_check("centre s3", 448, 0, 0, 0);
    scan_check("centre s4", 448, 0, 0, 0);

    // Extremes.
    sensors = 8'b1111_1110;
    scan_check("left s1", 448, 0, 0, 0);
    scan_check("left s2", 448, 0, 0, 0);
    scan_check("left s3", 0, 0, 0, 0);
    sensors = 8'b0111_1111;
    scan_check("right s1", 0, 0, 0, 0);
    scan_check("right s2", 0, 0, 0, 0);
    scan_check("right s3", 896, 0, 0, 1);

    // Line lost: two scans until bit 7 debounces away, then 7 holding scans, then LOST_CODE.
    sensors = 8'hFF;
    scan_check("lost pre1", 896, 0, 0, 1);
    scan_check("lost pre2", 896, 0, 0, 1);
    for (int i = 1; i <= 7; i++) scan_check($sformatf("lost empty%0d", i), 896, 0, 0, 1);
    scan_check("lost empty8", 2047, 1, 0, 1);

    sensors = 8'b1110_0111;
    scan_check("recover s1", 2047, 1, 0, 1);
    scan_check("recover s2", 2047, 1, 0, 1);
    scan_check("recover s3", 448, 0, 0, 1);

    // Two-tick glitch on bit 0 is filtered out; a three-tick one is accepted.
    sensors = 8'b1110_0110;
    scan_check("glitch s1", 448, 0, 0, 1);
    scan_check("glitch s2", 448, 0, 0, 1);
    sensors = 8'b1110_0111;
    scan_check("glitch end1", 448, 0, 0, 1);
    scan_check("glitch end2", 448, 0, 0, 1);
    sensors = 8'b1110_0110;
    scan_check("bit0 s1", 448, 0, 0, 1);
    scan_check("bit0 s2", 448, 0, 0, 1);
    scan_check("bit0 s3", 256, 0, 0, 0);

    // Junction, then a single sensor at bit 2.
    sensors = 8'h00;
    scan_check("junc s1", 256, 0, 0, 0);
    scan_check("junc s2", 256, 0, 0, 0);
    scan_check("junc s3", 448, 0, 1, 0);
    sensors = 8'b1111_1011;
    scan_check("bit2 s1", 448, 0, 1, 0);
    scan_check("bit2 s2", 448, 0, 1, 0);
    scan_check("bit2 s3", 256, 0, 0, 0);

    // Asynchronous reset in the middle of a scan, away from any clock edge.
    for (int i = 0; i < 2 * DIV && (cyc % DIV) != 4; i++) @(negedge clk);
    check("mid-scan reached", 32'(cyc % DIV), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("async position",  32'(position),  32'd0);
    check("async pos_valid", 32'(pos_valid), 32'd0);
    check("async junction",  32'(junction),  32'd0);
    check("async lost_side", 32'(lost_side), 32'd0);
    check("async line_lost", 32'(line_lost), 32'd0);
    repeat (12) @(negedge clk);
    check("held reset pos_valid", 32'(pos_valid), 32'd0);
    rst_n = 1'b1;
    scan_check("post-reset s1", 0, 0, 0, 0);
    check("post-reset strobe cycle", 32'(valid_cyc), 32'd25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/line_position_estimator.md
Name: line_position_estimator

Overview:
- Parametrised successor to the fixed 4-sensor position lookup in the line-follower datapath.
- Synchronises and debounces N reflectance sensors, then scans the debounced vector each sample period.
- Computes line position from the outermost active sensors and flags line-lost, junction and last-seen side.
- Feeds the steering/PID controller; position and pos_valid replace the old free-running position register.

Parameters:
N_SENSORS, 8, number of sensor inputs (2..16); bit 0 is leftmost.
POS_W, 11, position output width; must hold 2*(N_SENSORS-1)*HALF_STEP and LOST_CODE.
HALF_STEP, 64, position units per half sensor pitch.
SENSOR_ACTIVE_LOW, 1, 1 = a sensor reads 0 when over the line.
FILT_LEN, 4, consecutive identical samples needed to change a debounced bit (1..15).
SAMPLE_DIV, 1000, clocks per sample tick; must be at least N_SENSORS+2.
LOST_TIMEOUT, 8, consecutive empty scans before line_lost asserts (1..255).
LOST_CODE, 2047, position value driven while line_lost.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sensors  in  N_SENSORS  raw sensor levels, asynchronous to clk
position  out  POS_W  line position; 0 = under sensor 0
pos_valid  out  1  one-cycle strobe when position and flags update
line_lost  out  1  no line for LOST_TIMEOUT consecutive scans
junction  out  1  all sensors active in the last scan
lost_side  out  1  side the line was last seen on; 0 = left, 1 = right

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Assertion clears every register immediately.
- Reset values: position=0, pos_valid=0, line_lost=0, junction=0, lost_side=0. Synchroniser, filters, divider, lost counter and FSM state are all cleared.
- Input stage:
  - 2-flop synchroniser per bit.
  - Invert when SENSOR_ACTIVE_LOW=1, giving act[i] (1 = line).
- Divider:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - tick is high while the count equals SAMPLE_DIV-1.
- Debounce (per bit, on each tick):
  - If act[i] equals deb[i], clear cnt[i].
  - Otherwise increment cnt[i]. When it reaches FILT_LEN, set deb[i]=act[i] and clear cnt[i].
- FSM IDLE/SCAN/CALC:
  - Edge E0 (tick high in IDLE): snapshot the post-update deb into snap, clear min/max/count, go to SCAN with idx=0.
  - SCAN, edges E1..EN: examine snap[idx]; if set, min=min(min,idx), max=max(max,idx), count++. At idx=N_SENSORS-1, go to CALC.
  - CALC, edge E(N+1): register outputs, pulse pos_valid for exactly one cycle, return to IDLE.
  - Latency is N_SENSORS+1 clocks from the tick edge. A tick can never arrive outside IDLE (SAMPLE_DIV constraint); no queuing is required.
- CALC rules:
  - count>0:
    - position = (min+max)*HALF_STEP.
    - lost counter cleared, line_lost=0.
    - lost_side = 1 if min+max > N_SENSORS-1, else 0; unchanged if equal.
    - junction = (count==N_SENSORS).
  - count==0:
    - lost counter increments, saturating at LOST_TIMEOUT.
    - If the new value is below LOST_TIMEOUT, position holds and line_lost=0.
    - If it equals LOST_TIMEOUT, position=LOST_CODE and line_lost=1.
    - junction=0 and lost_side holds in both cases.
- Non-contiguous active sets, e.g. sensors 1 and 6, still use (min+max). No gap detection.
- Reset mid-scan aborts the scan. After release, the first pos_valid follows the first full tick.

Test Plan:
- Centre line: N=8, SAMPLE_DIV=16, FILT_LEN=3; hold sensors=8'b1110_0111 (bits 3,4 low) for 4 ticks -> position=448, junction=0, pos_valid pulses once per tick, 9 clocks after each tick edge.
- Extremes: only bit 0 low, stable -> position=0, lost_side=0; only bit 7 low -> position=896, lost_side=1.
- Debounce: centre line stable, then bit 0 low for 2 ticks only -> position stays 448; bit 0 low for 3 ticks -> position=(0+4)*64=256.
- Line lost: from position 896, all sensors high -> position holds 896 for 7 scans; at the 8th empty scan position=2047, line_lost=1, lost_side=1. Restoring bits 3,4 low -> line_lost=0 once debounce completes.
- Junction: all sensors low -> position=448, junction=1; the next scan with only bit 2 low gives junction=0, position=256.
- Async reset: assert rst_n=0 mid-SCAN without a clock edge -> all outputs 0 immediately; no pos_valid until one full tick plus 9 clocks after release.
